// File: rtl/nsc_pkg.sv
// Shared types for the nibble-serial comparator: FSM states, one-hot result
// encoding and the cascade-input resolver.
package nsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    // casc = {li, ei, gi}; ei outranks gi, which outranks li.
    function automatic logic [2:0] cascade_res(input logic [2:0] casc);
        logic [2:0] res;
        if (casc[1]) begin
            res = RES_EQ;
        end else if (casc[0]) begin
            res = RES_GT;
        end else if (casc[2]) begin
            res = RES_LT;
        end else begin
            res = RES_EQ;
        end
        return res;
    endfunction

endpackage

// File: rtl/nibble_cmp4.sv
// Combinational 4-bit unsigned magnitude compare with one-hot L/E/G outputs.
module nibble_cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       l,
    output logic       e,
    output logic       g
);

    always_comb begin
        l = (a < b);
        e = (a == b);
        g = (a > b);
    end

endmodule

// File: rtl/nibble_serial_comparator.sv
// Sequential wide-operand magnitude comparator walking 4-bit nibbles MSB-first.
// Optional build macro NSC_EARLY_EXIT_EN finishes on the first unequal nibble.
module nibble_serial_comparator
    import nsc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             li,
    input  logic             ei,
    input  logic             gi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int unsigned NNIB = WIDTH / 4;
    localparam int unsigned IW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]      casc_q, casc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            issuing_q, issuing_d;
    logic            nib_vld_q, nib_vld_d;
    logic            nib_last_q, nib_last_d;
    logic [2:0]      nib_res_q, nib_res_d;
    logic [2:0]      run_q, run_d;
    logic [2:0]      res_q, res_d;

    logic [3:0]      nib_a, nib_b;
    logic            cmp_l, cmp_e, cmp_g;
    logic [2:0]      upd;

    assign nib_a = a_q[4*int'(idx_q) +: 4];
    assign nib_b = b_q[4*int'(idx_q) +: 4];

    nibble_cmp4 u_cmp (
        .a (nib_a),
        .b (nib_b),
        .l (cmp_l),
        .e (cmp_e),
        .g (cmp_g)
    );

    // The slice result is registered before it folds into the running result,
    // so each nibble is consumed one cycle after it is selected.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        casc_d     = casc_q;
        idx_d      = idx_q;
        issuing_d  = issuing_q;
        nib_vld_d  = nib_vld_q;
        nib_last_d = nib_last_q;
        nib_res_d  = nib_res_q;
        run_d      = run_q;
        res_d      = res_q;
        upd        = (run_q == RES_EQ) ? nib_res_q : run_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    casc_d    = {li, ei, gi};
                    idx_d     = IW'(NNIB - 1);
                    issuing_d = 1'b1;
                    nib_vld_d = 1'b0;
                    run_d     = RES_EQ;
                    state_d   = RUN;
                end
            end
            RUN: begin
                nib_vld_d  = issuing_q;
                nib_last_d = (idx_q == '0);
                nib_res_d  = {cmp_l, cmp_e, cmp_g};
                if (issuing_q) begin
                    if (idx_q == '0) begin
                        issuing_d = 1'b0;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                if (nib_vld_q) begin
                    run_d = upd;
                    if (nib_last_q) begin
                        res_d   = (upd == RES_EQ) ? cascade_res(casc_q) : upd;
                        state_d = DONE;
                    end
`ifdef NSC_EARLY_EXIT_EN
                    else if (upd != RES_EQ) begin
                        res_d   = upd;
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                res_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            casc_q     <= '0;
            idx_q      <= '0;
            issuing_q  <= 1'b0;
            nib_vld_q  <= 1'b0;
            nib_last_q <= 1'b0;
            nib_res_q  <= '0;
            run_q      <= RES_EQ;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            casc_q     <= casc_d;
            idx_q      <= idx_d;
            issuing_q  <= issuing_d;
            nib_vld_q  <= nib_vld_d;
            nib_last_q <= nib_last_d;
            nib_res_q  <= nib_res_d;
            run_q      <= run_d;
            res_q      <= res_d;
        end
    end

    // Held low through reset, even after the first reset edge lands in IDLE.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign lt        = res_q[2];
    assign eq        = res_q[1];
    assign gt        = res_q[0];

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Directed bench for nibble_serial_comparator (WIDTH=16 and WIDTH=4 instances),
// with expected latencies following NSC_EARLY_EXIT_EN.
module tb_nibble_serial_comparator;

`ifdef NSC_EARLY_EXIT_EN
    localparam int LAT_MSB_DIFF = 2;
    localparam int LAT_NIB2_DIFF = 3;
`else
    localparam int LAT_MSB_DIFF = 5;
    localparam int LAT_NIB2_DIFF = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b;
    logic        li, ei, gi, lt, eq, gt;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4;
    logic        li4, ei4, gi4, lt4, eq4, gt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_comparator #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .li(li), .ei(ei), .gi(gi),
        .out_valid(out_valid), .out_ready(out_ready), .lt(lt), .eq(eq), .gt(gt)
    );

    nibble_serial_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .li(li4), .ei(ei4), .gi(gi4),
        .out_valid(out_valid4), .out_ready(out_ready4), .lt(lt4), .eq(eq4), .gt(gt4)
    );

    // Drive one bundle into dut16; returns just after the accept edge T.
    task automatic send16(input logic [15:0] va, input logic [15:0] vb,
                          input logic vl, input logic ve, input logic vg);
        @(negedge clk);
        a = va; b = vb; li = vl; ei = ve; gi = vg;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycles after T until out_valid is seen; 99 if it never rises.
    task automatic wait16(output int lat);
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic ack16();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic send4(input logic [3:0] va, input logic [3:0] vb,
                         input logic vl, input logic ve, input logic vg);
        @(negedge clk);
        a4 = va; b4 = vb; li4 = vl; ei4 = ve; gi4 = vg;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1 in_valid4 = 1'b0;
    endtask

    task automatic wait4(output int lat);
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid4) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic ack4();
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1 out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; li = 0; ei = 0; gi = 0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; li4 = 0; ei4 = 0; gi4 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, eq, gt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000", {out_valid, lt, eq, gt});
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, in_ready4} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b want 11", {in_ready, in_ready4});
        end
    endtask

    task automatic test_equal();
        int lat;
        send16(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
        wait16(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL equal_latency: got %0d want 5", lat);
        end
        checks++;
        if ({lt, eq, gt} !== 3'b010) begin
            errors++;
            $display("FAIL equal_result: got %b want 010", {lt, eq, gt});
        end
        ack16();
        checks++;
        if ({out_valid, lt, eq, gt} !== 4'b0000) begin
            errors++;
            $display("FAIL equal_after_ack: got %b want 0000", {out_valid, lt, eq, gt});
        end
    endtask

    task automatic test_msb_diff();
        int lat;
        send16(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        wait16(lat);
        checks++;
        if (lat !== LAT_MSB_DIFF) begin
            errors++;
            $display("FAIL msb_gt_latency: got %0d want %0d", lat, LAT_MSB_DIFF);
        end
        checks++;
        if ({lt, eq, gt} !== 3'b001) begin
            errors++;
            $display("FAIL msb_gt_result: got %b want 001", {lt, eq, gt});
        end
        ack16();
    endtask

    task automatic test_cascade();
        int lat;
        send16(16'h1233, 16'h1234, 1'b0, 1'b0, 1'b1);
        wait16(lat);
        checks++;
        if (lat !== 5 || {lt, eq, gt} !== 3'b100) begin
            errors++;
            $display("FAIL lsb_lt: got lat=%0d res=%b want lat=5 res=100", lat, {lt, eq, gt});
        end
        ack16();
        send16(16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1);
        wait16(lat);
        checks++;
        if ({lt, eq, gt} !== 3'b001) begin
            errors++;
            $display("FAIL cascade_gi: got %b want 001", {lt, eq, gt});
        end
        ack16();
        send16(16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0);
        wait16(lat);
        checks++;
        if ({lt, eq, gt} !== 3'b010) begin
            errors++;
            $display("FAIL cascade_none: got %b want 010", {lt, eq, gt});
        end
        ack16();
        send16(16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b1);
        wait16(lat);
        checks++;
        if ({lt, eq, gt} !== 3'b010) begin
            errors++;
            $display("FAIL cascade_ei_priority: got %b want 010", {lt, eq, gt});
        end
        ack16();
        send16(16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b1);
        wait16(lat);
        checks++;
        if ({lt, eq, gt} !== 3'b001) begin
            errors++;
            $display("FAIL cascade_gi_over_li: got %b want 001", {lt, eq, gt});
        end
        ack16();
        send16(16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b0);
        wait16(lat);
        checks++;
        if ({lt, eq, gt} !== 3'b100) begin
            errors++;
            $display("FAIL cascade_li: got %b want 100", {lt, eq, gt});
        end
        ack16();
    endtask

    task automatic test_backpressure();
        int lat;
        send16(16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0);
        wait16(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 5", lat);
        end
        // Offer a conflicting bundle while the result is held; it must be ignored.
        @(negedge clk);
        a = 16'h0000; b = 16'hFFFF; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, lt, eq, gt} !== 5'b10001) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %b want 10001", i,
                         {out_valid, in_ready, lt, eq, gt});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: got %b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        send16(16'h4000, 16'h1000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_result: got %b want 0", seen);
        end
        send16(16'h00FF, 16'h0100, 1'b0, 1'b0, 1'b1);
        wait16(lat);
        checks++;
        if (lat !== LAT_NIB2_DIFF || {lt, eq, gt} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_next: got lat=%0d res=%b want lat=%0d res=100",
                     lat, {lt, eq, gt}, LAT_NIB2_DIFF);
        end
        ack16();
    endtask

    task automatic test_width4();
        int lat;
        int bad;
        logic [3:0] ra, rb;
        logic [2:0] rc, want;
        send4(4'h3, 4'h9, 1'b0, 1'b0, 1'b0);
        wait4(lat);
        checks++;
        if (lat !== 2 || {lt4, eq4, gt4} !== 3'b100) begin
            errors++;
            $display("FAIL w4_directed: got lat=%0d res=%b want lat=2 res=100",
                     lat, {lt4, eq4, gt4});
        end
        ack4();
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rc = 3'($urandom_range(7));
            if (ra < rb)      want = 3'b100;
            else if (ra > rb) want = 3'b001;
            else if (rc[1])   want = 3'b010;
            else if (rc[0])   want = 3'b001;
            else if (rc[2])   want = 3'b100;
            else              want = 3'b010;
            send4(ra, rb, rc[2], rc[1], rc[0]);
            wait4(lat);
            checks++;
            if (lat !== 2 || {lt4, eq4, gt4} !== want) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL w4_random[%0d] a=%h b=%h c=%b: got lat=%0d res=%b want lat=2 res=%b",
                             i, ra, rb, rc, lat, {lt4, eq4, gt4}, want);
            end
            ack4();
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_diff();
        test_cascade();
        test_backpressure();
        test_reset_mid();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
